// File: rtl/datamem_arbiter_pkg.sv
// Shared types for the DataMemory port arbiter: FSM state and the read-return tag.
package datamem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_ACC = 2'd1,
      VID_ACC = 2'd2,
      KB_ACC  = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CPU  = 2'd1,
      VID  = 2'd2
   } ret_tag_t;

endpackage

// File: rtl/datamem_arbiter_starve_counter.sv
// Saturating count of consecutive video/keyboard grants taken while the CPU waits.
module arb_starve_counter #(
   parameter int STARVE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int CW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != CW'(STARVE))) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign at_limit = (cnt == CW'(STARVE));

endmodule

// File: rtl/datamem_arbiter.sv
// Shares the single DataMemory port between CPU load/store, video fetch and the
// keyboard mailbox; VID > KB > CPU, with a guaranteed CPU slot after STARVE grants.
module datamem_arbiter
   import datamem_arb_pkg::*;
#(
   parameter int bus     = 32,
   parameter int memsize = 256,
   parameter int KB_ADDR = memsize - 1,
   parameter int STARVE  = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           cpu_re,
   input  logic           cpu_we,
   input  logic [bus-1:0] cpu_addr,
   input  logic [bus-1:0] cpu_wdata,
   output logic [bus-1:0] cpu_rdata,
   output logic           cpu_done,
   output logic           cpu_stall,
   input  logic           vid_req,
   input  logic [bus-1:0] vid_addr,
   output logic           vid_gnt,
   output logic [bus-1:0] vid_rdata,
   output logic           vid_valid,
   input  logic           kb_req,
   input  logic [bus-1:0] kb_data,
   output logic           kb_ack,
   output logic [bus-1:0] mem_addr,
   output logic [bus-1:0] mem_wdata,
   output logic           mem_re,
   output logic           mem_we,
   input  logic [bus-1:0] mem_rdata,
   output logic           addr_err
);

   // Handshake: cpu_re/cpu_we are held until the one-cycle cpu_done pulse; vid_req is
   // a level, each cycle it is sampled high earns one vid_gnt cycle; kb_req is a strobe.
   arb_state_t     state, state_nx;
   ret_tag_t       ret_tag;
   logic           ret_zero;
   logic [bus-1:0] cap_addr, cap_wdata;
   logic           cap_wr, cap_oor;
   logic [bus-1:0] kb_hold;
   logic           kb_pend;
   logic           err_q;
   logic           at_limit;
   logic           cpu_req, cpu_pend, kb_elig, cpu_oor, vid_oor;
   logic           starve_inc, starve_clr;

   always_comb begin
      cpu_req  = cpu_re | cpu_we;
      // The CPU is ineligible from its grant until its completion pulse.
      cpu_pend = cpu_req & (state != CPU_ACC) & (ret_tag != CPU);
      kb_elig  = kb_req | (kb_pend & (state != KB_ACC));
      cpu_oor  = (cpu_addr >= bus'(memsize));
      vid_oor  = (vid_addr >= bus'(memsize));

      state_nx = IDLE;
      if (cpu_pend && at_limit)  state_nx = CPU_ACC;
      else if (vid_req)          state_nx = VID_ACC;
      else if (kb_elig)          state_nx = KB_ACC;
      else if (cpu_pend)         state_nx = CPU_ACC;

      starve_inc = cpu_pend & ((state_nx == VID_ACC) | (state_nx == KB_ACC));
      starve_clr = ~cpu_pend | (state_nx == CPU_ACC);
   end

   arb_starve_counter #(.STARVE(STARVE)) u_starve (
      .clk      (clk),
      .reset    (reset),
      .inc      (starve_inc),
      .clr      (starve_clr),
      .at_limit (at_limit)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         ret_tag   <= NONE;
         ret_zero  <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_wr    <= 1'b0;
         cap_oor   <= 1'b0;
         kb_hold   <= '0;
         kb_pend   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nx;

         case (state_nx)
            CPU_ACC: begin
               cap_addr  <= cpu_addr;
               cap_wdata <= cpu_wdata;
               cap_wr    <= cpu_we;
               cap_oor   <= cpu_oor;
            end
            VID_ACC: begin
               cap_addr  <= vid_addr;
               cap_wdata <= '0;
               cap_wr    <= 1'b0;
               cap_oor   <= vid_oor;
            end
            default: begin
               cap_addr  <= '0;
               cap_wdata <= '0;
               cap_wr    <= 1'b0;
               cap_oor   <= 1'b0;
            end
         endcase

         // Tag the read issued this cycle so next cycle's mem_rdata reaches its owner.
         case (state)
            CPU_ACC: ret_tag <= cap_wr ? NONE : CPU;
            VID_ACC: ret_tag <= VID;
            default: ret_tag <= NONE;
         endcase
         ret_zero <= cap_oor;

         if (kb_req) begin
            kb_hold <= kb_data;
            kb_pend <= 1'b1;
         end else if (state == KB_ACC) begin
            kb_pend <= 1'b0;
         end

         if (((state_nx == CPU_ACC) && cpu_oor) || ((state_nx == VID_ACC) && vid_oor))
            err_q <= 1'b1;
      end
   end

   // Outputs decode the registered state; while reset is low everything reads zero.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      cpu_done  = 1'b0;
      cpu_rdata = '0;
      cpu_stall = 1'b0;
      vid_gnt   = 1'b0;
      vid_valid = 1'b0;
      vid_rdata = '0;
      kb_ack    = 1'b0;
      addr_err  = 1'b0;
      if (reset) begin
         case (state)
            CPU_ACC: begin
               mem_addr  = cap_addr;
               mem_wdata = cap_wdata;
               mem_re    = ~cap_wr & ~cap_oor;
               mem_we    = cap_wr & ~cap_oor;
               cpu_done  = cap_wr;
            end
            VID_ACC: begin
               mem_addr = cap_addr;
               mem_re   = ~cap_oor;
               vid_gnt  = 1'b1;
            end
            KB_ACC: begin
               mem_addr  = bus'(KB_ADDR);
               mem_wdata = kb_hold;
               mem_we    = 1'b1;
               kb_ack    = 1'b1;
            end
            default: ;
         endcase

         if (ret_tag == CPU) begin
            cpu_done  = 1'b1;
            cpu_rdata = ret_zero ? '0 : mem_rdata;
         end
         if (ret_tag == VID) begin
            vid_valid = 1'b1;
            vid_rdata = ret_zero ? '0 : mem_rdata;
         end

         cpu_stall = cpu_req & ~cpu_done;
         addr_err  = err_q;
      end
   end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed scenarios followed by random traffic, all outputs compared every cycle
// against a transaction-level model of the arbitration rules.
module tb_datamem_arbiter;

   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_re, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_done, cpu_stall;
   logic        vid_req;
   logic [31:0] vid_addr, vid_rdata;
   logic        vid_gnt, vid_valid;
   logic        kb_req;
   logic [31:0] kb_data;
   logic        kb_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_re, mem_we;
   logic        addr_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   datamem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_re    (cpu_re),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_done  (cpu_done),
      .cpu_stall (cpu_stall),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_gnt   (vid_gnt),
      .vid_rdata (vid_rdata),
      .vid_valid (vid_valid),
      .kb_req    (kb_req),
      .kb_data   (kb_data),
      .kb_ack    (kb_ack),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .addr_err  (addr_err)
   );

   function automatic logic [31:0] seed_word(input int i);
      if (i == 5) return 32'hDEADBEEF;
      return {i[15:0] ^ 16'hA5C3, ~i[15:0]};
   endfunction

   // DataMemory stand-in: garbage on mem_rdata when no read was issued.
   logic [31:0] dmem [256];
   logic        mem_load;
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 256; i++) dmem[i] <= seed_word(i);
      end else if (mem_we && mem_addr < 256) begin
         dmem[mem_addr[7:0]] <= mem_wdata;
      end
      mem_rdata <= (mem_re && mem_addr < 256) ? dmem[mem_addr[7:0]] : $urandom;
   end

   // Reference model: g = owner of the current cycle (0 none, 1 cpu, 2 vid, 3 kb),
   // r = owner of the read data returning this cycle.
   logic [31:0] ref_mem [256];
   int          g, r, starve, kb_w;
   logic [31:0] kb_word, cur_addr, cur_wdata, r_data;
   logic        cur_wr, m_err, e_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic sample();
      logic inr, e_re, e_we;
      @(negedge clk);
      inr    = (cur_addr < 256);
      e_re   = reset && (((g == 1) && !cur_wr && inr) || ((g == 2) && inr));
      e_we   = reset && (((g == 1) && cur_wr && inr) || (g == 3));
      e_done = reset && (((g == 1) && cur_wr) || (r == 1));
      chk("mem_re", mem_re, e_re);
      chk("mem_we", mem_we, e_we);
      if (e_re || e_we || !reset)
         chk("mem_addr", mem_addr, !reset ? 32'd0 : (g == 3) ? 32'd255 : cur_addr);
      if (e_we || !reset)
         chk("mem_wdata", mem_wdata, !reset ? 32'd0 : (g == 3) ? kb_word : cur_wdata);
      chk("cpu_done", cpu_done, e_done);
      if ((reset && r == 1) || !reset)
         chk("cpu_rdata", cpu_rdata, reset ? r_data : 32'd0);
      chk("cpu_stall", cpu_stall, reset && (cpu_re || cpu_we) && !e_done);
      chk("vid_gnt", vid_gnt, reset && (g == 2));
      chk("vid_valid", vid_valid, reset && (r == 2));
      if ((reset && r == 2) || !reset)
         chk("vid_rdata", vid_rdata, reset ? r_data : 32'd0);
      chk("kb_ack", kb_ack, reset && (g == 3));
      chk("addr_err", addr_err, reset && m_err);
   endtask

   task automatic advance();
      int          ng, nr;
      logic [31:0] nrd;
      logic        cpu_seen, kb_seen, inr;
      @(posedge clk);
      if (!reset) begin
         g = 0; r = 0; r_data = 0; starve = 0; kb_w = 0; kb_word = 0;
         m_err = 0; cur_addr = 0; cur_wdata = 0; cur_wr = 0;
      end else begin
         inr = (cur_addr < 256);
         nr = 0;
         nrd = 0;
         if ((g == 1 && !cur_wr) || g == 2) begin
            nr  = (g == 1) ? 1 : 2;
            nrd = inr ? ref_mem[cur_addr[7:0]] : 32'd0;
         end
         if (g == 1 && cur_wr && inr) ref_mem[cur_addr[7:0]] = cur_wdata;
         if (g == 3) ref_mem[255] = kb_word;
         cpu_seen = (cpu_re || cpu_we) && (g != 1) && (r != 1);
         kb_seen  = kb_req || (kb_w != 0 && g != 3);
         if (cpu_seen && starve == STARVE) ng = 1;
         else if (vid_req)                 ng = 2;
         else if (kb_seen)                 ng = 3;
         else if (cpu_seen)                ng = 1;
         else                              ng = 0;
         if (!cpu_seen || ng == 1) starve = 0;
         else if (starve < STARVE) starve++;
         if (kb_req) begin
            kb_w = 1;
            kb_word = kb_data;
         end else if (g == 3) begin
            kb_w = 0;
         end
         if (ng == 1) begin
            cur_addr = cpu_addr; cur_wdata = cpu_wdata; cur_wr = cpu_we;
            if (cpu_addr >= 256) m_err = 1;
         end else if (ng == 2) begin
            cur_addr = vid_addr; cur_wdata = 0; cur_wr = 0;
            if (vid_addr >= 256) m_err = 1;
         end
         g = ng;
         r = nr;
         r_data = nrd;
      end
      #1;
      if (e_done) begin
         cpu_re = 1'b0;
         cpu_we = 1'b0;
      end
      kb_req = 1'b0;
   endtask

   task automatic cyc();
      sample();
      advance();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nvid, nkb, n, k;
      logic got;
      int ord [3];

      reset = 1'b0; cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      vid_req = 0; vid_addr = 0; kb_req = 0; kb_data = 0; mem_load = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
      g = 0; r = 0; r_data = 0; starve = 0; kb_w = 0; kb_word = 0;
      m_err = 0; cur_addr = 0; cur_wdata = 0; cur_wr = 0; e_done = 0;

      // reset state
      sample();
      chk("rst_cpu_done", cpu_done, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_addr_err", addr_err, 0);
      advance();
      mem_load = 1'b0;
      reset = 1'b1;
      cyc();

      // uncontended CPU read of address 5
      cpu_re = 1; cpu_addr = 5;
      sample(); chk("t1_stall_t", cpu_stall, 1); advance();
      sample(); chk("t1_mem_re", mem_re, 1); chk("t1_mem_addr", mem_addr, 5);
      chk("t1_stall_t1", cpu_stall, 1); advance();
      sample(); chk("t1_done", cpu_done, 1); chk("t1_rdata", cpu_rdata, 32'hDEADBEEF); advance();
      sample(); chk("t1_stall_after", cpu_stall, 0); advance();

      // starvation bound under continuous video
      vid_req = 1; vid_addr = 40;
      cyc(); cyc();
      cpu_we = 1; cpu_addr = 3; cpu_wdata = 32'hCAFE0003;
      cyc();
      nvid = 0; got = 0;
      for (int i = 0; i < 12 && !got; i++) begin
         sample();
         if (cpu_done) begin
            got = 1;
            chk("t2_wr_we", mem_we, 1);
            chk("t2_wr_addr", mem_addr, 3);
         end else if (vid_gnt) begin
            nvid++;
         end
         advance();
      end
      chk("t2_done_seen", got, 1);
      chk("t2_vid_count", nvid, 4);
      sample(); chk("t2_vid_resumes", vid_gnt, 1); advance();

      // keyboard overwrite while video holds the port
      kb_req = 1; kb_data = 32'h1C; cyc();
      cyc();
      kb_req = 1; kb_data = 32'h32; cyc();
      vid_req = 0;
      nkb = 0;
      for (int i = 0; i < 6; i++) begin
         sample();
         if (kb_ack) begin
            nkb++;
            chk("t3_kb_data", mem_wdata, 32'h32);
            chk("t3_kb_addr", mem_addr, 255);
         end
         advance();
      end
      chk("t3_kb_count", nkb, 1);

      // simultaneous requests from idle
      vid_req = 1; vid_addr = 20; kb_req = 1; kb_data = 32'h77; cpu_re = 1; cpu_addr = 9;
      sample(); advance();
      vid_req = 0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         sample();
         if (vid_gnt) begin
            if (n < 3) ord[n] = 2;
            n++;
         end else if (kb_ack) begin
            if (n < 3) ord[n] = 3;
            n++;
         end else if (mem_re) begin
            if (n < 3) ord[n] = 1;
            n++;
         end
         if (vid_valid) chk("t4_vid_data", vid_rdata, seed_word(20));
         if (cpu_done) chk("t4_cpu_data", cpu_rdata, seed_word(9));
         advance();
      end
      chk("t4_grants", n, 3);
      chk("t4_first_vid", ord[0], 2);
      chk("t4_second_kb", ord[1], 3);
      chk("t4_third_cpu", ord[2], 1);

      // out-of-range CPU read
      cpu_re = 1; cpu_addr = 300;
      sample(); advance();
      sample(); chk("t5_no_re", mem_re, 0); chk("t5_no_we", mem_we, 0); advance();
      sample(); chk("t5_done", cpu_done, 1); chk("t5_zero", cpu_rdata, 0);
      chk("t5_err", addr_err, 1); advance();
      cyc(); cyc();
      sample(); chk("t5_err_sticky", addr_err, 1); advance();

      // reset right after a video access, with a keyboard word pending
      vid_req = 1; vid_addr = 7; kb_req = 1; kb_data = 32'h55;
      cyc();
      sample(); chk("t6_vid_gnt", vid_gnt, 1); advance();
      reset = 0; vid_req = 0;
      sample(); chk("t6_no_valid", vid_valid, 0); chk("t6_err_clr", addr_err, 0);
      chk("t6_no_re", mem_re, 0); advance();
      reset = 1;
      nkb = 0;
      for (int i = 0; i < 4; i++) begin
         sample();
         if (kb_ack) nkb++;
         chk("t6_valid_idle", vid_valid, 0);
         advance();
      end
      chk("t6_kb_dropped", nkb, 0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         reset   = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
         vid_req = ($urandom_range(0, 99) < 40);
         vid_addr = ($urandom_range(0, 19) == 0) ? 32'(256 + $urandom_range(0, 1000))
                                                 : 32'($urandom_range(0, 255));
         kb_req  = ($urandom_range(0, 9) == 0);
         kb_data = $urandom;
         if (!cpu_re && !cpu_we && $urandom_range(0, 9) < 3) begin
            k = $urandom_range(0, 2);
            cpu_re = (k != 1);
            cpu_we = (k != 0);
            cpu_addr = ($urandom_range(0, 15) == 0) ? 32'(256 + $urandom_range(0, 1000))
                                                    : 32'($urandom_range(0, 255));
            cpu_wdata = $urandom;
         end
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
